exec_unit: RTL and testbench

//  Execute/write-back stage that consumes the register-file read operands (Adata/Bdata) and produces its write port (din/DA/RW).
//  - Accepts one decoded op per valid/ready handshake.
//  - Computes single-cycle ALU results or a multi-cycle shift-add multiply.
//  - Issues exactly one register write per result-producing op and keeps Z/N/C status flags.

---
 rtl/exec_unit.sv | 197 +++++++++++++++++++
 tb/tb_exec_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execute/write-back stage: single-cycle ALU ops plus an optional shift-add multiplier,
// driving the register-file write port. Define EXEC_MUL_EN to build the multiplier (op C).
module exec_unit #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op,
  input  logic [BW-1:0] a_data,
  input  logic [BW-1:0] b_data,
  input  logic [3:0]    dst,
  output logic [BW-1:0] din,
  output logic [3:0]    DA,
  output logic          RW,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_c,
  output logic [1:0]    fsm_state
);

  // Handshake: an op transfers on a rising edge where in_valid && in_ready.
  // in_ready is high only in IDLE; in_valid is ignored while busy.

  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_INC = 4'hA;
  localparam logic [3:0] OP_DEC = 4'hB;

`ifdef EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, MUL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1} state_t;
`endif

  state_t state, state_n;

  logic          accept;
  logic          is_mul;
  logic          alu_wr;
  logic [BW-1:0] alu_res;
  logic          alu_c;
  logic [BW:0]   alu_sum;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign fsm_state = state;

  // Result is computed straight from the accepted operands, so later operand changes cannot leak in.
  always_comb begin
    alu_wr  = 1'b1;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_sum = '0;
    case (op)
      OP_MOV: alu_res = a_data;
      OP_ADD: begin
        alu_sum = {1'b0, a_data} + {1'b0, b_data};
        alu_res = alu_sum[BW-1:0];
        alu_c   = alu_sum[BW];
      end
      OP_SUB: begin
        alu_sum = {1'b0, a_data} - {1'b0, b_data};
        alu_res = alu_sum[BW-1:0];
        alu_c   = alu_sum[BW];
      end
      OP_AND: alu_res = a_data & b_data;
      OP_OR:  alu_res = a_data | b_data;
      OP_XOR: alu_res = a_data ^ b_data;
      OP_NOT: alu_res = ~a_data;
      OP_SHL: begin
        alu_res = {a_data[BW-2:0], 1'b0};
        alu_c   = a_data[BW-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_data[BW-1:1]};
        alu_c   = a_data[0];
      end
      OP_INC: begin
        alu_sum = {1'b0, a_data} + {{BW{1'b0}}, 1'b1};
        alu_res = alu_sum[BW-1:0];
        alu_c   = alu_sum[BW];
      end
      OP_DEC: begin
        alu_sum = {1'b0, a_data} - {{BW{1'b0}}, 1'b1};
        alu_res = alu_sum[BW-1:0];
        alu_c   = alu_sum[BW];
      end
      default: alu_wr = 1'b0;
    endcase
  end

`ifdef EXEC_MUL_EN
  logic [BW-1:0] mul_a;
  logic [BW-1:0] mul_b;
  logic [BW-1:0] mul_acc;
  logic [BW-1:0] mul_sum;
  logic [3:0]    mul_dst;
  logic [CW-1:0] mul_cnt;
  logic          mul_last;

  assign is_mul   = (op == OP_MUL);
  // Only the low BW product bits are kept, so the partial sum never needs to grow.
  assign mul_sum  = mul_acc + (mul_b[0] ? mul_a : '0);
  assign mul_last = (mul_cnt == CW'(BW - 1));
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept && is_mul) begin
`ifdef EXEC_MUL_EN
          state_n = MUL;
`endif
        end else if (accept && alu_wr) begin
          state_n = WB;
        end
      end
      WB: state_n = IDLE;
`ifdef EXEC_MUL_EN
      MUL: if (mul_last) state_n = WB;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      din    <= '0;
      DA     <= '0;
      RW     <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_n;
      RW    <= 1'b0;
      if (accept && alu_wr) begin
        din    <= alu_res;
        DA     <= dst;
        RW     <= 1'b1;
        flag_z <= (alu_res == '0);
        flag_n <= alu_res[BW-1];
        flag_c <= alu_c;
      end
`ifdef EXEC_MUL_EN
      if (state == MUL && mul_last) begin
        din    <= mul_sum;
        DA     <= mul_dst;
        RW     <= 1'b1;
        flag_z <= (mul_sum == '0);
        flag_n <= mul_sum[BW-1];
        flag_c <= 1'b0;
      end
`endif
    end
  end

`ifdef EXEC_MUL_EN
  // One multiplier bit per cycle: multiplicand shifts left, multiplier shifts right.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_dst <= '0;
      mul_cnt <= '0;
    end else if (accept && is_mul) begin
      mul_a   <= a_data;
      mul_b   <= b_data;
      mul_acc <= '0;
      mul_dst <= dst;
      mul_cnt <= '0;
    end else if (state == MUL) begin
      mul_a   <= {mul_a[BW-2:0], 1'b0};
      mul_b   <= {1'b0, mul_b[BW-1:1]};
      mul_acc <= mul_sum;
      mul_cnt <= mul_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit (BW=8): directed ops push expected writes, a monitor
// compares every RW pulse. MUL sequences are exercised when EXEC_MUL_EN is defined.
module tb_exec_unit;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = '0;
  logic [BW-1:0] a_data = '0;
  logic [BW-1:0] b_data = '0;
  logic [3:0]    dst = '0;
  logic [BW-1:0] din;
  logic [3:0]    DA;
  logic          RW;
  logic          flag_z, flag_n, flag_c;
  logic [1:0]    fsm_state;

  // Expected entry: {check_c, c, n, z, da[3:0], din[7:0]}
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  int n_pass = 0;
  int n_chk  = 0;

  exec_unit #(.BW(BW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a_data(a_data), .b_data(b_data), .dst(dst),
    .din(din), .DA(DA), .RW(RW),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", name, got, want);
  endtask

  function automatic logic [15:0] ex(input logic cc, input logic c, input logic n, input logic z,
                                     input logic [3:0] da, input logic [7:0] d);
    return {cc, c, n, z, da, d};
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && RW) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write DA=%0h din=%0h want no write", DA, din);
      end else begin
        mon_e = exp_q.pop_front();
        check("din", 32'(din), 32'(mon_e[7:0]));
        check("DA", 32'(DA), 32'(mon_e[11:8]));
        check("flag_z", 32'(flag_z), 32'(mon_e[12]));
        check("flag_n", 32'(flag_n), 32'(mon_e[13]));
        if (mon_e[15]) check("flag_c", 32'(flag_c), 32'(mon_e[14]));
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] d, input bit wr, input logic [15:0] e);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL issue_timeout in_ready=0 want 1");
      return;
    end
    op = o; a_data = a; b_data = b; dst = d; in_valid = 1'b1;
    if (wr) exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_idle_hold(input string name, input logic [2:0] znc,
                                 input logic [7:0] d, input logic [3:0] da);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check({name, "_rw"}, 32'(RW), 0);
      check({name, "_ready"}, 32'(in_ready), 1);
    end
    check({name, "_flags"}, 32'({flag_z, flag_n, flag_c}), 32'(znc));
    check({name, "_din"}, 32'(din), 32'(d));
    check({name, "_da"}, 32'(DA), 32'(da));
  endtask

  initial begin
    logic [3:0] nop_ops [3];
    nop_ops[0] = 4'h0; nop_ops[1] = 4'hE; nop_ops[2] = 4'hC;

    repeat (2) @(negedge clk);
    check("rst_din", 32'(din), 0);
    check("rst_DA", 32'(DA), 0);
    check("rst_RW", 32'(RW), 0);
    check("rst_flags", 32'({flag_z, flag_n, flag_c}), 0);
    check("rst_ready", 32'(in_ready), 1);
    rst = 1'b1;

    // ADD latency: write in the next cycle, gone the cycle after.
    issue(4'h2, 8'h7F, 8'h01, 4'h3, 1, ex(1, 0, 1, 0, 4'h3, 8'h80));
    @(negedge clk);
    check("lat_rw_high", 32'(RW), 1);
    check("lat_ready_low", 32'(in_ready), 0);
    @(negedge clk);
    check("lat_rw_low", 32'(RW), 0);
    check("lat_ready_back", 32'(in_ready), 1);

    issue(4'h2, 8'hFF, 8'h01, 4'h1, 1, ex(1, 1, 0, 1, 4'h1, 8'h00));
    issue(4'h3, 8'h00, 8'h01, 4'h2, 1, ex(1, 1, 1, 0, 4'h2, 8'hFF));
    issue(4'h1, 8'h5A, 8'h33, 4'h4, 1, ex(0, 0, 0, 0, 4'h4, 8'h5A));
    issue(4'h4, 8'hF0, 8'h3C, 4'h5, 1, ex(0, 0, 0, 0, 4'h5, 8'h30));
    issue(4'h5, 8'hF0, 8'h0C, 4'h6, 1, ex(0, 0, 1, 0, 4'h6, 8'hFC));
    issue(4'h6, 8'hAA, 8'hAA, 4'h7, 1, ex(0, 0, 0, 1, 4'h7, 8'h00));
    issue(4'h7, 8'h0F, 8'h00, 4'h8, 1, ex(0, 0, 1, 0, 4'h8, 8'hF0));
    issue(4'h8, 8'h81, 8'h00, 4'h1, 1, ex(1, 1, 0, 0, 4'h1, 8'h02));
    issue(4'h9, 8'h81, 8'h00, 4'h2, 1, ex(1, 1, 0, 0, 4'h2, 8'h40));
    issue(4'h9, 8'h02, 8'h00, 4'h3, 1, ex(1, 0, 0, 0, 4'h3, 8'h01));
    issue(4'hA, 8'hFF, 8'h00, 4'h4, 1, ex(1, 1, 0, 1, 4'h4, 8'h00));
    issue(4'hA, 8'h7F, 8'h00, 4'h5, 1, ex(1, 0, 1, 0, 4'h5, 8'h80));
    issue(4'h3, 8'h09, 8'h04, 4'h6, 1, ex(1, 0, 0, 0, 4'h6, 8'h05));
    issue(4'h2, 8'h01, 8'h02, 4'hF, 1, ex(1, 0, 0, 0, 4'hF, 8'h03));
    issue(4'hB, 8'h00, 8'h00, 4'h7, 1, ex(1, 1, 1, 0, 4'h7, 8'hFF));

    // NOP-class ops: no write, flags and write port hold DEC's values.
`ifdef EXEC_MUL_EN
    for (int i = 0; i < 2; i++) begin
`else
    for (int i = 0; i < 3; i++) begin
`endif
      issue(nop_ops[i], 8'h12, 8'h34, 4'h9, 0, 16'h0);
      check_idle_hold("nop", 3'b011, 8'hFF, 4'h7);
    end

`ifdef EXEC_MUL_EN
    // MUL with an ADD held on the inputs the whole time it is busy.
    @(negedge clk);
    op = 4'hC; a_data = 8'h0C; b_data = 8'h0B; dst = 4'h5; in_valid = 1'b1;
    exp_q.push_back(ex(1, 0, 1, 0, 4'h5, 8'h84));
    @(posedge clk);
    #1 op = 4'h2; a_data = 8'h10; b_data = 8'h20; dst = 4'h6;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("mul_ready_low", 32'(in_ready), 0);
      check("mul_rw", 32'(RW), (k == 9) ? 1 : 0);
    end
    exp_q.push_back(ex(1, 0, 0, 0, 4'h6, 8'h30));
    @(negedge clk);
    check("mul_ready_back", 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;

    issue(4'hC, 8'hFF, 8'hFF, 4'h1, 1, ex(1, 0, 0, 0, 4'h1, 8'h01));
    issue(4'hC, 8'h10, 8'h10, 4'h2, 1, ex(1, 0, 0, 1, 4'h2, 8'h00));

    // Reset in the middle of a multiply: nothing may be written.
    issue(4'hC, 8'h03, 8'h03, 4'h4, 0, 16'h0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mrst_rw", 32'(RW), 0);
    check("mrst_din", 32'(din), 0);
    check("mrst_DA", 32'(DA), 0);
    check("mrst_flags", 32'({flag_z, flag_n, flag_c}), 0);
    check("mrst_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    issue(4'h2, 8'h01, 8'h01, 4'h6, 1, ex(1, 0, 0, 0, 4'h6, 8'h02));
`endif

    repeat (15) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
